traverse_mask_acc: RTL

- Parametrised successor of the per-pixel traverse-mask weighting stage.
- Takes one centre pixel with NCH channels, then streams all neighbours of a (2*RAD_I+1)x(2*RAD_J+1) window.
- Per neighbour: computes a colour-correlation weight (programmable LUT per channel difference, product over channels) and a distance weight (programmable LUT on di^2+dj^2).
- Accumulates the weight sum and the weighted per-channel pixel sums, then returns them through a valid/ready output. Feeds the over-exposure-correction normaliser.

---
 rtl/traverse_mask_acc.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/traverse_mask_acc.sv
// Traverse-mask weighting accumulator: per-neighbour colour/distance LUT weights,
// accumulated into a weight sum and weighted per-channel pixel sums.
module traverse_mask_acc #(
  parameter int NCH     = 4,
  parameter int DW_IN   = 10,
  parameter int DW_DEC  = 8,
  parameter int RAD_I   = 6,
  parameter int RAD_J   = 12,
  parameter int CLUT_AW = 6,
  parameter int CSHIFT  = 4,
  parameter int DLUT_AW = 8,
  localparam int WIN  = (2*RAD_I+1)*(2*RAD_J+1),
  localparam int CW   = $clog2(WIN+1),
  localparam int WS_W = DW_DEC+1+CW,
  localparam int PS_W = DW_IN+CW,
  localparam int DI_W = $clog2(RAD_I+1),
  localparam int DJ_W = $clog2(RAD_J+1),
  localparam int LA_W = (CLUT_AW > DLUT_AW) ? CLUT_AW : DLUT_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NCH*DW_IN-1:0]  ctr_pix,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DW_IN-1:0]  in_pix,
  input  logic [DI_W-1:0]       in_di,
  input  logic [DJ_W-1:0]       in_dj,
  input  logic                  lut_we,
  input  logic                  lut_sel,
  input  logic [LA_W-1:0]       lut_addr,
  input  logic [DW_DEC:0]       lut_wdata,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WS_W-1:0]       out_wsum,
  output logic [NCH*PS_W-1:0]   out_psum
);

  localparam int PW    = NCH*DW_IN;
  localparam int WW    = DW_DEC+1;
  localparam int DQ_W  = 2*DJ_W+DLUT_AW+1;
  localparam int DRAIN = 6;
  localparam logic [WW-1:0]    ONE  = WW'(1) << DW_DEC;
  localparam logic [DW_IN-1:0] PMAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_FLUSH, ST_OUT} state_t;

  // Fixed-point multiply with round-half-up; both operands are <= 1.0.
  function automatic logic [WW-1:0] wmul(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [2*WW-1:0] p;
    p = ({{WW{1'b0}}, a} * {{WW{1'b0}}, b}) + ((2*WW)'(1) << (DW_DEC-1));
    return p[DW_DEC +: WW];
  endfunction

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] flush_q, flush_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [PW-1:0] ctr_q, ctr_d;
  logic hs, clr, load_out;

  logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [PW-1:0] pix0_q, pix0_d, pix1_q, pix1_d, pix2_q, pix2_d, pix3_q, pix3_d;
  logic [DI_W-1:0] di0_q, di0_d;
  logic [DJ_W-1:0] dj0_q, dj0_d;
  logic [NCH-1:0][CLUT_AW-1:0] cidx1_q, cidx1_d;
  logic [DLUT_AW-1:0] didx1_q, didx1_d;
  logic [NCH-1:0][WW-1:0] wc2_q, wc2_d;
  logic [WW-1:0] wd2_q, wd2_d, wcor3_q, wcor3_d, wd3_q, wd3_d, w4_q, w4_d;
  logic [NCH-1:0][DW_IN-1:0] pw4_q, pw4_d;
  logic [WS_W-1:0] wsum_q, wsum_d, out_wsum_q, out_wsum_d;
  logic [NCH-1:0][PS_W-1:0] psum_q, psum_d;
  logic [NCH*PS_W-1:0] out_psum_q, out_psum_d;

  logic [WW-1:0] clut_q [2**CLUT_AW];
  logic [WW-1:0] dlut_q [2**DLUT_AW];
  logic [WW-1:0] wdata_clamped;
  logic clut_wr, dlut_wr;

  // Handshakes: a neighbour is taken on any edge with in_valid && in_ready; a
  // result is held until the edge with out_valid && out_ready.
  assign hs = in_valid && in_ready_q;

  always_comb begin
    wdata_clamped = (lut_wdata > ONE) ? ONE : lut_wdata;
    clut_wr = lut_we && !lut_sel && (state_q == ST_IDLE) && ((lut_addr >> CLUT_AW) == '0);
    dlut_wr = lut_we &&  lut_sel && (state_q == ST_IDLE) && ((lut_addr >> DLUT_AW) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2**CLUT_AW; k++) clut_q[k] <= ONE;
      for (int k = 0; k < 2**DLUT_AW; k++) dlut_q[k] <= ONE;
    end else begin
      if (clut_wr) clut_q[lut_addr[CLUT_AW-1:0]] <= wdata_clamped;
      if (dlut_wr) dlut_q[lut_addr[DLUT_AW-1:0]] <= wdata_clamped;
    end
  end

  always_comb begin
    logic [DW_IN-1:0] a, b, d, sh;
    logic [DQ_W-1:0] dq;
    logic [DW_IN+WW-1:0] pp;
    logic [DW_IN:0] pq;
    a = '0; b = '0; d = '0; sh = '0; dq = '0; pp = '0; pq = '0;

    state_d = state_q; cnt_d = cnt_q; flush_d = flush_q; ctr_d = ctr_q;
    in_ready_d = in_ready_q; out_valid_d = out_valid_q;
    clr = 1'b0; load_out = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        ctr_d = ctr_pix; cnt_d = '0; clr = 1'b1;
        in_ready_d = 1'b1; state_d = ST_ACC;
      end
      ST_ACC: if (hs) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIN-1)) begin
          in_ready_d = 1'b0; flush_d = '0; state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Wait until the last sample has reached the accumulator.
        flush_d = flush_q + 3'd1;
        if (flush_q == 3'(DRAIN-1)) begin
          out_valid_d = 1'b1; load_out = 1'b1; state_d = ST_OUT;
        end
      end
      ST_OUT: if (out_ready) begin
        out_valid_d = 1'b0; state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    v0_d = hs; pix0_d = in_pix; di0_d = in_di; dj0_d = in_dj;

    v1_d = v0_q; pix1_d = pix0_q;
    for (int c = 0; c < NCH; c++) begin
      a = pix0_q[c*DW_IN +: DW_IN];
      b = ctr_q[c*DW_IN +: DW_IN];
      d = (a >= b) ? a - b : b - a;
      sh = d >> CSHIFT;
      cidx1_d[c] = (sh > DW_IN'(2**CLUT_AW-1)) ? '1 : sh[CLUT_AW-1:0];
    end
    dq = DQ_W'(di0_q) * DQ_W'(di0_q) + DQ_W'(dj0_q) * DQ_W'(dj0_q);
    didx1_d = (dq > DQ_W'(2**DLUT_AW-1)) ? '1 : dq[DLUT_AW-1:0];

    v2_d = v1_q; pix2_d = pix1_q;
    for (int c = 0; c < NCH; c++) wc2_d[c] = clut_q[cidx1_q[c]];
    wd2_d = dlut_q[didx1_q];

    v3_d = v2_q; pix3_d = pix2_q; wd3_d = wd2_q;
    wcor3_d = wc2_q[0];
    for (int c = 1; c < NCH; c++) wcor3_d = wmul(wcor3_d, wc2_q[c]);

    v4_d = v3_q;
    w4_d = wmul(wcor3_q, wd3_q);
    for (int c = 0; c < NCH; c++) begin
      pp = (DW_IN+WW)'(pix3_q[c*DW_IN +: DW_IN]) * (DW_IN+WW)'(w4_d)
         + ((DW_IN+WW)'(1) << (DW_DEC-1));
      pq = pp[DW_DEC +: DW_IN+1];
      pw4_d[c] = (pq > {1'b0, PMAX}) ? PMAX : pq[DW_IN-1:0];
    end

    wsum_d = wsum_q; psum_d = psum_q;
    if (clr) begin
      wsum_d = '0; psum_d = '0;
    end else if (v4_q) begin
      wsum_d = wsum_q + WS_W'(w4_q);
      for (int c = 0; c < NCH; c++) psum_d[c] = psum_q[c] + PS_W'(pw4_q[c]);
    end

    out_wsum_d = out_wsum_q; out_psum_d = out_psum_q;
    if (load_out) begin
      out_wsum_d = wsum_q; out_psum_d = psum_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; cnt_q <= '0; flush_q <= '0; ctr_q <= '0;
      in_ready_q <= 1'b0; out_valid_q <= 1'b0;
      v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
      pix0_q <= '0; pix1_q <= '0; pix2_q <= '0; pix3_q <= '0;
      di0_q <= '0; dj0_q <= '0; cidx1_q <= '0; didx1_q <= '0;
      wc2_q <= '0; wd2_q <= '0; wcor3_q <= '0; wd3_q <= '0; w4_q <= '0; pw4_q <= '0;
      wsum_q <= '0; psum_q <= '0; out_wsum_q <= '0; out_psum_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; flush_q <= flush_d; ctr_q <= ctr_d;
      in_ready_q <= in_ready_d; out_valid_q <= out_valid_d;
      v0_q <= v0_d; v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; v4_q <= v4_d;
      pix0_q <= pix0_d; pix1_q <= pix1_d; pix2_q <= pix2_d; pix3_q <= pix3_d;
      di0_q <= di0_d; dj0_q <= dj0_d; cidx1_q <= cidx1_d; didx1_q <= didx1_d;
      wc2_q <= wc2_d; wd2_q <= wd2_d; wcor3_q <= wcor3_d; wd3_q <= wd3_d;
      w4_q <= w4_d; pw4_q <= pw4_d;
      wsum_q <= wsum_d; psum_q <= psum_d; out_wsum_q <= out_wsum_d; out_psum_q <= out_psum_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign out_wsum  = out_wsum_q;
  assign out_psum  = out_psum_q;

endmodule
